// File: rtl/mult_seq_ctrl.sv
// Sequencer for the signed shift-add multiplier datapath, WIDTH-bit operands.
// Define MULT_SEQ_SKIP_ZERO_EN to fold the shift into ADD when the multiplier bit is zero.
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  input  logic M,
  output logic clr_ld,
  output logic add,
  output logic sub,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAdd,
    StShift,
    StHold
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_bit;

  // The final bit is the two's-complement sign bit and is subtracted, not added.
  assign last_bit = (cnt_q == CntLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_ld  = 1'b0;
    add     = 1'b0;
    sub     = 1'b0;
    shift   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        clr_ld = clear;
        if (run) state_d = StLoad;
      end
      StLoad: begin
        clr_ld  = 1'b1;
        busy    = 1'b1;
        cnt_d   = '0;
        state_d = StAdd;
      end
      StAdd: begin
        busy = 1'b1;
        if (M) begin
          add     = !last_bit;
          sub     = last_bit;
          state_d = StShift;
        end else begin
`ifdef MULT_SEQ_SKIP_ZERO_EN
          shift = 1'b1;
          if (last_bit) state_d = StHold;
          else          cnt_d   = cnt_q + CntW'(1);
`else
          state_d = StShift;
`endif
        end
      end
      StShift: begin
        busy  = 1'b1;
        shift = 1'b1;
        if (last_bit) begin
          state_d = StHold;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = StAdd;
        end
      end
      StHold: begin
        done   = 1'b1;
        clr_ld = clear;
        // Run must drop before a new operation can start.
        if (!run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: an 8-bit and a 4-bit instance, each fed by a
// small model of the multiplier register, with a scoreboard of per-operation results.
module tb_mult_seq_ctrl;

  localparam int unsigned WA = 8;
  localparam int unsigned WB = 4;
`ifdef MULT_SEQ_SKIP_ZERO_EN
  localparam bit Skip = 1'b1;
`else
  localparam bit Skip = 1'b0;
`endif

  typedef struct {
    int unsigned lat;
    logic [63:0] add_m;
    logic [63:0] sub_m;
    int unsigned shifts;
  } op_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] run_s, clear_s, m_s;
  logic [1:0] clr_ld_s, add_s, sub_s, shift_s, busy_s, done_s;

  logic [63:0] mult_v [2];
  logic [63:0] b_q    [2];
  logic [1:0]  ld_n = '0, sh_n = '0;

  logic [1:0]  active = '0;
  int unsigned cyc    [2] = '{0, 0};
  int unsigned shifts [2] = '{0, 0};
  int unsigned viol   [2] = '{0, 0};
  logic [63:0] add_m  [2];
  logic [63:0] sub_m  [2];
  op_t         r;

  op_t exp_q0[$], exp_q1[$], obs_q0[$], obs_q1[$];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(WA)) u_dut_a (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (run_s[0]),
    .clear  (clear_s[0]),
    .M      (m_s[0]),
    .clr_ld (clr_ld_s[0]),
    .add    (add_s[0]),
    .sub    (sub_s[0]),
    .shift  (shift_s[0]),
    .busy   (busy_s[0]),
    .done   (done_s[0])
  );

  mult_seq_ctrl #(.WIDTH(WB)) u_dut_b (
    .clk    (clk),
    .reset_n(reset_n),
    .run    (run_s[1]),
    .clear  (clear_s[1]),
    .M      (m_s[1]),
    .clr_ld (clr_ld_s[1]),
    .add    (add_s[1]),
    .sub    (sub_s[1]),
    .shift  (shift_s[1]),
    .busy   (busy_s[1]),
    .done   (done_s[1])
  );

  // Multiplier register model: loaded on clr_ld, shifted right on shift.
  assign m_s[0] = b_q[0][0];
  assign m_s[1] = b_q[1][0];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (ld_n[u])      b_q[u] <= mult_v[u];
      else if (sh_n[u]) b_q[u] <= b_q[u] >> 1;
    end
  end

  // Monitor: strobes are sampled mid-cycle; one record per completed operation.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      ld_n[u] <= clr_ld_s[u];
      sh_n[u] <= shift_s[u];
      if (!reset_n) begin
        active[u] <= 1'b0;
      end else begin
        if ((add_s[u] && sub_s[u]) || (shift_s[u] && (add_s[u] || sub_s[u])) ||
            (busy_s[u] && done_s[u]))
          viol[u] <= viol[u] + 1;
        if (busy_s[u] && clr_ld_s[u]) begin
          active[u] <= 1'b1;
          cyc[u]    <= 0;
          shifts[u] <= 0;
          add_m[u]  <= '0;
          sub_m[u]  <= '0;
        end else if (active[u]) begin
          cyc[u] <= cyc[u] + 1;
          if (add_s[u])   add_m[u]  <= add_m[u] | (64'd1 << shifts[u]);
          if (sub_s[u])   sub_m[u]  <= sub_m[u] | (64'd1 << shifts[u]);
          if (shift_s[u]) shifts[u] <= shifts[u] + 1;
          if ((clr_ld_s[u] && !done_s[u]) || (!busy_s[u] && !done_s[u]))
            viol[u] <= viol[u] + 1;
          if (done_s[u]) begin
            active[u] <= 1'b0;
            r.lat    = cyc[u] + 1;
            r.add_m  = add_m[u];
            r.sub_m  = sub_m[u];
            r.shifts = shifts[u];
            if (u == 0) obs_q0.push_back(r);
            else        obs_q1.push_back(r);
          end
        end
      end
    end
  end

  function automatic op_t model(int unsigned w, logic [63:0] mult);
    op_t         e;
    logic [63:0] m;
    m        = mult & ((64'd1 << w) - 64'd1);
    e.lat    = Skip ? (1 + w + $countones(m)) : (2 * w + 1);
    e.add_m  = m & ((64'd1 << (w - 1)) - 64'd1);
    e.sub_m  = m & (64'd1 << (w - 1));
    e.shifts = w;
    return e;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load the operand, queue the expectation and raise run (held if hold_run).
  task automatic start_op(int u, logic [63:0] mult, bit hold_run);
    mult_v[u] = mult;
    if (u == 0) exp_q0.push_back(model(WA, mult));
    else        exp_q1.push_back(model(WB, mult));
    @(posedge clk); #1;
    run_s[u] = 1'b1;
    @(posedge clk); #1;
    if (!hold_run) run_s[u] = 1'b0;
  endtask

  task automatic finish_op(int u, string tag);
    op_t e, o;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_s[u]) break;
    end
    #1;
    check({tag, " done"}, 64'(done_s[u]), 64'd1);
    check({tag, " result"}, 64'((u == 0) ? obs_q0.size() : obs_q1.size()), 64'd1);
    if (u == 0 && obs_q0.size() > 0 && exp_q0.size() > 0) begin
      o = obs_q0.pop_front();
      e = exp_q0.pop_front();
    end else if (u == 1 && obs_q1.size() > 0 && exp_q1.size() > 0) begin
      o = obs_q1.pop_front();
      e = exp_q1.pop_front();
    end else begin
      return;
    end
    check({tag, " latency"}, 64'(o.lat), 64'(e.lat));
    check({tag, " add pattern"}, o.add_m, e.add_m);
    check({tag, " sub pattern"}, o.sub_m, e.sub_m);
    check({tag, " shifts"}, 64'(o.shifts), 64'(e.shifts));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nsh;
    op_t junk;
    reset_n = 1'b0;
    run_s   = '0;
    clear_s = 2'b01;
    #2;
    check("reset clr_ld follows clear=1", 64'(clr_ld_s[0]), 64'd1);
    clear_s = '0;
    #1;
    check("reset clr_ld follows clear=0", 64'(clr_ld_s[0]), 64'd0);
    check("reset strobes", 64'({add_s, sub_s, shift_s}), 64'd0);
    check("reset busy", 64'(busy_s), 64'd0);
    check("reset done", 64'(done_s), 64'd0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;

    start_op(0, 64'h00, 1'b0);
    finish_op(0, "w8 x00");

    // Run held through completion: done must persist, clear in HOLD only loads.
    start_op(0, 64'hFF, 1'b1);
    finish_op(0, "w8 xFF");
    repeat (2) begin
      @(negedge clk);
      check("hold with run high", 64'(done_s[0]), 64'd1);
    end
    @(posedge clk); #1 clear_s[0] = 1'b1;
    @(negedge clk);
    check("hold clear clr_ld", 64'(clr_ld_s[0]), 64'd1);
    check("hold clear done", 64'(done_s[0]), 64'd1);
    @(negedge clk);
    check("hold clear stays", 64'({done_s[0], busy_s[0]}), 64'b10);
    @(posedge clk); #1 clear_s[0] = 1'b0; run_s[0] = 1'b0;
    @(negedge clk);
    check("done in cycle run falls", 64'(done_s[0]), 64'd1);
    @(negedge clk);
    check("done after run falls", 64'(done_s[0]), 64'd0);

    start_op(0, 64'h05, 1'b0);
    finish_op(0, "w8 x05");

    // Asynchronous reset during the 5th shift aborts the operation.
    start_op(0, 64'hA5, 1'b0);
    nsh = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (shift_s[0]) nsh++;
      if (nsh == 5) break;
    end
    check("reached 5th shift", 64'(nsh), 64'd5);
    #1 reset_n = 1'b0;
    #1;
    check("abort strobes", 64'({add_s[0], sub_s[0], shift_s[0]}), 64'd0);
    check("abort busy", 64'(busy_s[0]), 64'd0);
    check("abort done", 64'(done_s[0]), 64'd0);
    check("abort clr_ld", 64'(clr_ld_s[0]), 64'd0);
    if (exp_q0.size() > 0) junk = exp_q0.pop_front();
    @(negedge clk);
    #1 reset_n = 1'b1;
    start_op(0, 64'hA5, 1'b0);
    finish_op(0, "w8 xA5 after reset");
    @(posedge clk);

    // clear held and run toggled while busy must not disturb the sequence.
    start_op(0, 64'h3C, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      clear_s[0] = 1'b1;
      run_s[0]   = i[0];
    end
    @(posedge clk); #1;
    clear_s[0] = 1'b0;
    run_s[0]   = 1'b0;
    finish_op(0, "w8 x3C clear/run busy");

    start_op(1, 64'hA, 1'b0);
    finish_op(1, "w4 b1010");
    @(posedge clk);

    check("w8 invariants", 64'(viol[0]), 64'd0);
    check("w4 invariants", 64'(viol[1]), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
